instr_fetch_buffer: RTL

Fetch-side buffer between the program counter and the pipeline decode stage. It issues each PC-generated fetch address to instruction memory and tracks outstanding requests against a credit limit. Returned instruction words are queued in order, tagged with their fetch PC, and presented to decode over a valid/ready handshake. A redirect `flush` (taken branch, JAL, JALR) empties the queue and silently discards every response still in flight.

---
 rtl/instr_fetch_buffer.sv | 106 ++++++++++
 1 files changed

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: fetch-side queue between the PC and decode.
// Issues PC fetch addresses to instruction memory under a credit limit,
// queues returned words in order tagged with their PC, and presents them
// to decode over valid/ready. A flush empties the queue and arranges for
// every still-outstanding memory response to be silently dropped.
//
// Ports:
//   clk, reset (async, active-low)
//   pc_valid/pc_addr/pc_ready         : fetch address from the PC
//   flush                             : redirect, discard queued + in-flight
//   imem_req_valid/addr/ready         : request to instruction memory
//   imem_rsp_valid/data               : in-order response, no backpressure
//   dec_valid/dec_instr/dec_pc/ready  : head entry to decode
module instr_fetch_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_valid,
    input  logic [31:0] pc_addr,
    output logic        pc_ready,
    input  logic        flush,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        dec_valid,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    input  logic        dec_ready
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    // Pointers carry one extra MSB so full and empty differ.
    logic [PW-1:0] r_alloc;
    logic [PW-1:0] r_fill;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_discard;
    logic [31:0]   r_pc    [DEPTH];
    logic [31:0]   r_instr [DEPTH];

    logic [PW-1:0] w_occupancy;
    logic [PW-1:0] w_inflight;
    logic          w_credit;
    logic          w_rsp_ok;
    logic          w_req_fire;
    logic          w_dec_fire;

    // Occupancy counts allocated-but-unconsumed slots plus responses still owed
    // to a flushed stream; both fit in PW bits since neither exceeds DEPTH.
    assign w_occupancy = (r_alloc - r_head) + r_discard;
    assign w_inflight  = (r_alloc - r_fill) + r_discard;
    assign w_credit    = (w_occupancy < PW'(DEPTH));

    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_rsp_ok    = imem_rsp_valid && (w_inflight != '0);

    assign imem_req_valid = pc_valid && w_credit && !flush;
    assign pc_ready       = imem_req_ready && w_credit && !flush;
    assign imem_req_addr  = pc_addr;

    assign w_req_fire  = pc_valid && pc_ready;
    assign dec_valid   = (r_fill != r_head);
    assign dec_instr   = r_instr[r_head[AW-1:0]];
    assign dec_pc      = r_pc[r_head[AW-1:0]];
    assign w_dec_fire  = dec_valid && dec_ready;

    // Queue state; flush overrides every other update in its cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alloc   <= '0;
            r_fill    <= '0;
            r_head    <= '0;
            r_discard <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_pc[i]    <= '0;
                r_instr[i] <= '0;
            end
        end else if (flush) begin
            // The response landing in the flush cycle is itself dropped.
            r_discard <= w_inflight - PW'(w_rsp_ok);
            r_head    <= r_alloc;
            r_fill    <= r_alloc;
        end else begin
            if (w_req_fire) begin
                r_pc[r_alloc[AW-1:0]] <= pc_addr;
                r_alloc               <= r_alloc + PW'(1);
            end
            if (w_rsp_ok) begin
                if (r_discard != '0) begin
                    r_discard <= r_discard - PW'(1);
                end else begin
                    r_instr[r_fill[AW-1:0]] <= imem_rsp_data;
                    r_fill                  <= r_fill + PW'(1);
                end
            end
            if (w_dec_fire) begin
                r_head <= r_head + PW'(1);
            end
        end
    end

endmodule
